debounce_bank: RTL
==================

# debounce_bank

Multi-channel, parametrised successor to the single-input pushbutton debouncer. Each channel passes through a 2-flop synchroniser and a stability counter, then drives a debounced level and single-cycle rise and fall strobes. An optional auto-repeat strobe lets the game FSM and cursor logic treat a held button as a stream of move events. It sits between the board pins (`btn*`, `sw`) and all consumers in the 65 MHz `clk_65mhz` domain.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `DB_COUNT`, 1_000_000: consecutive stable synchronised cycles required before `clean_out` changes (≥2).
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 ties `repeat_out` to 0 and removes the repeat logic.
- `REPEAT_DELAY`, 32_500_000: cycles from the rise to the first repeat strobe (≥2). 0.5 s at 65 MHz.
- `REPEAT_PERIOD`, 6_500_000: cycles between subsequent repeat strobes (≥2). 0.1 s at 65 MHz.
- `clk_in  input  1`: system clock. One clock; all logic on posedge.
- `rst_in  input  1`: reset, synchronous and active-high.
- `noisy_in  input  CHANNELS`: raw asynchronous inputs, one bit per channel.
- `clean_out  output  CHANNELS`: debounced level.
- `rise_out  output  CHANNELS`: 1-cycle strobe when `clean_out` goes 0→1.
- `fall_out  output  CHANNELS`: 1-cycle strobe when `clean_out` goes 1→0.
- `repeat_out  output  CHANNELS`: 1-cycle strobe on each rise, then periodically while the channel is held.

## Operation
- **Channel independence:** all per-channel state is replicated. No channel affects another.
- **Synchroniser:** `s1 <= noisy_in`, then `s2 <= s1`.
- **Debounce state:** `cand` (candidate level) and `cnt`. `cnt` width is `$clog2(DB_COUNT)`.
- **Debounce update, priority order each cycle:**
  - `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Else if `cnt == DB_COUNT-1`: `clean_out <= cand`, `cnt` holds (saturates).
  - Else: `cnt <= cnt+1`.
- **Edge strobes:** `rise_out`/`fall_out` are registered in the same cycle `clean_out` changes and are high for exactly one cycle. If `cand == clean_out` at saturation, no strobe fires.
- **Glitches:** any `s2` toggle shorter than `DB_COUNT` cycles restarts `cnt`. No output changes.
- **Auto-repeat FSM per channel** (`REPEAT_EN=1`), states IDLE, DELAY, PERIOD, with counter `rcnt` of width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))`:
  - IDLE, on rise: pulse `repeat_out`, `rcnt <= 0`, go to DELAY.
  - DELAY: `rcnt++`. At `rcnt == REPEAT_DELAY-1`: pulse, `rcnt <= 0`, go to PERIOD.
  - PERIOD: `rcnt++`. At `rcnt == REPEAT_PERIOD-1`: pulse, `rcnt <= 0`, stay in PERIOD.
  - Fall in any state: go to IDLE, `rcnt <= 0`, no pulse. Fall has priority over a coincident repeat terminal count.
- **Reset values:** `s1`, `s2`, `cand`, `clean_out`, `rise_out`, `fall_out`, `repeat_out` = 0; `cnt` = 0, `rcnt` = 0; FSM in IDLE.
- **Held input at reset release:** an input held high through reset produces a normal debounced rise after release.
- **Reset mid-operation:** all state is discarded immediately; in-flight strobes do not complete.

## Timing
- **Debounce latency:** new stable level first sampled into `s1` at edge k → `clean_out` and strobe visible after edge k+DB_COUNT+2.
- **After reset:** reset asserted at edge r, input high throughout → `clean_out`/`rise_out` high after edge r+DB_COUNT+3.
- **Repeat schedule:** rise strobe after edge R → repeat strobes after edges R, R+REPEAT_DELAY, R+REPEAT_DELAY+n·REPEAT_PERIOD (n≥1).
- **Strobe alignment:** `rise_out` and the first `repeat_out` are coincident. All strobes are registered; no combinational path from input to output.

## Test plan
Parameters for all scenarios: `CHANNELS=2`, `DB_COUNT=4`, `REPEAT_DELAY=8`, `REPEAT_PERIOD=3`.
- **Clean press:** ch0 0→1 sampled at edge 10 → `clean_out[0]`=1 and `rise_out[0]` pulse after edge 16; `rise_out` low after edge 17; ch1 stays 0.
- **Bounce:** ch0 toggles 1,0,1,0,1 for 2 cycles each, then holds 1 → exactly one `rise_out` pulse, 6 cycles after the final transition is sampled; no `fall_out`.
- **Auto-repeat:** hold ch1 high, rise at edge R → `repeat_out[1]` pulses at R, R+8, R+11, R+14. Release → `fall_out[1]` pulse; no further repeats.
- **Fall vs repeat:** fall timed to coincide with a PERIOD terminal count → `fall_out` pulses; `repeat_out` stays 0 on that cycle.
- **Reset mid-hold:** hold ch0 high; assert `rst_in` one cycle while `clean_out[0]`=1 → all outputs 0 the next cycle. Rise reappears 7 cycles after the reset edge.
- **`REPEAT_EN=0`:** same hold as the auto-repeat scenario → `repeat_out` stays 0 throughout; `rise_out`/`fall_out` unchanged.

Source files
------------

// File: rtl/debounce_bank.sv
// +--------------------------------------------------------------------------+
// | debounce_bank: multi-channel input debouncer with edge and auto-repeat   |
// | strobes.                                       Revision: 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int DB_COUNT      = 1_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 32_500_000,
  parameter int REPEAT_PERIOD = 6_500_000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [CHANNELS-1:0] noisy_in,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] rise_out,
  output logic [CHANNELS-1:0] fall_out,
  output logic [CHANNELS-1:0] repeat_out
);

  localparam int            CW      = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_DELAY  = 2'd1,
    RS_PERIOD = 2'd2
  } rep_state_t;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] rise_evt;
  logic [CHANNELS-1:0] fall_evt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= noisy_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic          cand;
    logic [CW-1:0] cnt;
    logic          clean_q;
    logic          rise_q;
    logic          fall_q;
    logic          sat;

    // Saturated and stable: the candidate is now the debounced level.
    assign sat         = (s2[i] == cand) && (cnt == CNT_MAX);
    assign rise_evt[i] = sat && cand && !clean_q;
    assign fall_evt[i] = sat && !cand && clean_q;

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        cand    <= 1'b0;
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= rise_evt[i];
        fall_q <= fall_evt[i];
        if (s2[i] != cand) begin
          cand <= s2[i];
          cnt  <= '0;
        end else if (cnt == CNT_MAX) begin
          clean_q <= cand;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign clean_out[i] = clean_q;
    assign rise_out[i]  = rise_q;
    assign fall_out[i]  = fall_q;
  end

  if (REPEAT_EN != 0) begin : g_repeat
    for (genvar i = 0; i < CHANNELS; i++) begin : g_rep_chan
      rep_state_t    st;
      rep_state_t    st_n;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] rcnt_n;
      logic          rep_q;
      logic          rep_n;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          st    <= RS_IDLE;
          rcnt  <= '0;
          rep_q <= 1'b0;
        end else begin
          st    <= st_n;
          rcnt  <= rcnt_n;
          rep_q <= rep_n;
        end
      end

      // A release wins over a terminal count landing in the same cycle.
      always_comb begin
        st_n   = st;
        rcnt_n = rcnt;
        rep_n  = 1'b0;
        if (fall_evt[i]) begin
          st_n   = RS_IDLE;
          rcnt_n = '0;
        end else begin
          case (st)
            RS_IDLE: begin
              if (rise_evt[i]) begin
                rep_n  = 1'b1;
                rcnt_n = '0;
                st_n   = RS_DELAY;
              end
            end
            RS_DELAY: begin
              if (rcnt == DELAY_MAX) begin
                rep_n  = 1'b1;
                rcnt_n = '0;
                st_n   = RS_PERIOD;
              end else begin
                rcnt_n = rcnt + 1'b1;
              end
            end
            RS_PERIOD: begin
              if (rcnt == PERIOD_MAX) begin
                rep_n  = 1'b1;
                rcnt_n = '0;
              end else begin
                rcnt_n = rcnt + 1'b1;
              end
            end
            default: begin
              st_n   = RS_IDLE;
              rcnt_n = '0;
            end
          endcase
        end
      end

      assign repeat_out[i] = rep_q;
    end
  end else begin : g_no_repeat
    assign repeat_out = '0;
  end

endmodule

`default_nettype wire
